regfile_writeback_unit: RTL and testbench

//  Writer side of the 32x32 register-file write port (A3/WD3/WE3).

---
 rtl/regfile_writeback_unit.sv | 122 ++++++++++++
 tb/tb_regfile_writeback_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_unit.sv
// Writeback queue feeding the register-file write port (A3/WD3/WE3), with ALU-over-load arbitration.
// Optional same-cycle bypass when the queue is idle: define WB_BYPASS_EN.
module regfile_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  input  logic                     rf_hold,
  input  logic [AW-1:0]            q_addr,
  output logic                     q_pending,
  output logic [AW-1:0]            A3,
  output logic [DW-1:0]            WD3,
  output logic                     WE3,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] count;

  logic          full, empty;
  logic          alu_fire, mem_fire, in_fire, in_live;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          bypass, push, pop;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // Readiness looks only at full, so a full queue refuses a push even while it pops.
  assign alu_ready = !full;
  assign mem_ready = !full && !alu_valid;

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;
  assign in_fire  = alu_fire || mem_fire;
  assign in_addr  = alu_fire ? alu_addr : mem_addr;
  assign in_data  = alu_fire ? alu_data : mem_data;
  // Writes to r0 are accepted and silently discarded.
  assign in_live  = in_fire && (in_addr != '0);

`ifdef WB_BYPASS_EN
  assign bypass = in_live && empty && !rf_hold;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_live && !bypass;
  assign pop  = !empty && !rf_hold;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    WE3 = pop || bypass;
    A3  = '0;
    WD3 = '0;
    if (bypass) begin
      A3  = in_addr;
      WD3 = in_data;
    end else if (!empty) begin
      A3  = addr_mem[rd_ptr];
      WD3 = data_mem[rd_ptr];
    end
  end

  always_comb begin
    logic [PW-1:0] idx;
    q_pending = 1'b0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((LW'(i) < count) && (addr_mem[idx] == q_addr))
        q_pending = 1'b1;
    end
`ifdef WB_BYPASS_EN
    if (in_live && (in_addr == q_addr))
      q_pending = 1'b1;
`endif
    if (q_addr == '0)
      q_pending = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; entry validity comes from count, which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit in its default (queued, no bypass) build.
module tb_regfile_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, rf_hold;
  logic [4:0]  alu_addr, mem_addr, q_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, q_pending, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [2:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_writeback_unit #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_hold(rf_hold), .q_addr(q_addr), .q_pending(q_pending),
    .A3(A3), .WD3(WD3), .WE3(WE3), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; alu_valid = 0; mem_valid = 0; rf_hold = 0;
    alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0; q_addr = 0;

    // 1) reset, then a single ALU write appears one cycle after acceptance
    tick(); tick();
    rst = 1'b0;
    check("rst_we3", WE3, 0);
    check("rst_a3", A3, 0);
    check("rst_wd3", WD3, 0);
    check("rst_level", level, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_q_pending", q_pending, 0);
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; q_addr = 5;
    #1;
    check("t1_no_same_cycle_we3", WE3, 0);
    check("t1_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    #1;
    check("t1_we3", WE3, 1);
    check("t1_a3", A3, 5);
    check("t1_wd3", WD3, 32'hDEADBEEF);
    check("t1_level", level, 1);
    check("t1_q_pending", q_pending, 1);
    tick();
    check("t1_drained_level", level, 0);
    check("t1_drained_we3", WE3, 0);
    check("t1_drained_q_pending", q_pending, 0);

    // 2) simultaneous ALU and load requests; ALU wins, load follows
    alu_valid = 1; alu_addr = 3; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 4; mem_data = 32'h22;
    #1;
    check("t2_alu_ready", alu_ready, 1);
    check("t2_mem_ready", mem_ready, 0);
    tick();
    alu_valid = 0;
    #1;
    check("t2_mem_ready_after", mem_ready, 1);
    check("t2_w1_we3", WE3, 1);
    check("t2_w1_a3", A3, 3);
    check("t2_w1_wd3", WD3, 32'h11);
    tick();  // pop 3 and push 4 on the same edge
    mem_valid = 0;
    #1;
    check("t2_pushpop_level", level, 1);
    check("t2_w2_we3", WE3, 1);
    check("t2_w2_a3", A3, 4);
    check("t2_w2_wd3", WD3, 32'h22);
    tick();
    check("t2_level", level, 0);

    // 3) fill under rf_hold, a full queue refuses a push while popping, then drain in order
    rf_hold = 1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_addr = 5'(i); alu_data = 32'h100 + i;
      tick();
    end
    alu_addr = 9; alu_data = 32'h999;
    #1;
    check("t3_full_level", level, 4);
    check("t3_full_alu_ready", alu_ready, 0);
    check("t3_full_mem_ready", mem_ready, 0);
    check("t3_hold_we3", WE3, 0);
    check("t3_hold_a3", A3, 1);
    check("t3_hold_wd3", WD3, 32'h101);
    rf_hold = 0;
    #1;
    check("t3_full_pop_alu_ready", alu_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t3_we3", WE3, 1);
      check("t3_a3", A3, i);
      check("t3_wd3", WD3, 32'h100 + i);
      check("t3_level", level, 5 - i);
      tick();
      alu_valid = 0;
    end
    check("t3_drained_level", level, 0);
    check("t3_drained_we3", WE3, 0);

    // 4) writes to r0 are accepted but never queued or written
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF; q_addr = 0;
    #1;
    check("t4_alu_ready", alu_ready, 1);
    check("t4_q_pending_r0", q_pending, 0);
    tick();
    alu_valid = 0;
    #1;
    check("t4_level", level, 0);
    check("t4_we3", WE3, 0);
    tick();
    check("t4_we3_later", WE3, 0);

    // 5) two writes to the same register land in order; hazard query tracks them
    rf_hold = 1;
    alu_valid = 1; alu_addr = 7; alu_data = 32'hA;
    tick();
    alu_data = 32'hB;
    tick();
    alu_valid = 0; q_addr = 7;
    #1;
    check("t5_q_pending", q_pending, 1);
    check("t5_level", level, 2);
    q_addr = 8;
    #1;
    check("t5_q_pending_other", q_pending, 0);
    q_addr = 7; rf_hold = 0;
    #1;
    check("t5_w1_a3", A3, 7);
    check("t5_w1_wd3", WD3, 32'hA);
    check("t5_w1_we3", WE3, 1);
    tick();
    check("t5_w2_wd3", WD3, 32'hB);
    check("t5_w2_we3", WE3, 1);
    check("t5_w2_q_pending", q_pending, 1);
    tick();
    check("t5_q_pending_cleared", q_pending, 0);
    check("t5_we3_idle", WE3, 0);

    // 6) reset mid-operation drops queued writes
    rf_hold = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_addr = 5'(10 + i); alu_data = 32'h200 + i;
      tick();
    end
    alu_valid = 0;
    #1;
    check("t6_level_before", level, 3);
    rst = 1;
    tick();
    rst = 0; rf_hold = 0;
    #1;
    check("t6_level", level, 0);
    check("t6_we3", WE3, 0);
    check("t6_a3", A3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_write", WE3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
